// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multiply instruction sequencer between decoder and multiplier
module mul_sequencer #(
  parameter int IREG    = 1,
  parameter int OREG    = 0,
  parameter int PAIR_WR = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op_sel,
  input  logic [7:0]  rd_data,
  input  logic [7:0]  rr_data,
  output logic        busy,
  output logic [7:0]  ai,
  output logic [7:0]  bi,
  output logic        op_mul,
  output logic        op_muls,
  output logic        op_mulsu,
  output logic        op_fmul,
  output logic        op_fmuls,
  output logic        op_fmulsu,
  input  logic [15:0] mu_ro,
  input  logic        mu_cf,
  input  logic        mu_zf,
  output logic        wr_en,
  output logic        wr_pair,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        sreg_we,
  output logic        sreg_c,
  output logic        sreg_z,
  output logic        done
);

  // Total multiplier pipeline depth; the counter walks EXEC for LAT cycles.
  localparam int LAT = IREG + OREG;
  localparam logic [1:0] CNT_INIT = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_WB_HI = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_op;
  logic [1:0]  r_cnt;
  logic [7:0]  r_hold;
  logic        w_accept;
  logic        w_op_act;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus all state-decoded outputs; nothing here depends on start except w_accept.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_op_act = 1'b0;
    busy     = (r_state != S_IDLE);
    wr_en    = 1'b0;
    wr_pair  = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 16'h0000;
    sreg_we  = 1'b0;
    sreg_c   = 1'b0;
    sreg_z   = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (op_sel <= 3'd5)) begin
          w_accept = 1'b1;
          w_next   = (LAT > 0) ? S_EXEC : S_WB;
        end
      end
      S_EXEC: begin
        w_op_act = 1'b1;
        if (r_cnt == 2'd0) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        // Enables stay up here because the multiplier gates its flags with them.
        w_op_act = 1'b1;
        sreg_we  = 1'b1;
        sreg_c   = mu_cf;
        sreg_z   = mu_zf;
        wr_en    = 1'b1;
        if (PAIR_WR != 0) begin
          wr_pair = 1'b1;
          wr_data = mu_ro;
          done    = 1'b1;
          w_next  = S_IDLE;
        end else begin
          wr_data = {8'h00, mu_ro[7:0]};
          w_next  = S_WB_HI;
        end
      end
      S_WB_HI: begin
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = {8'h00, r_hold};
        done    = 1'b1;
        w_next  = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand/op capture on accept, latency countdown, and high-byte hold for split writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ai     <= 8'h00;
      bi     <= 8'h00;
      r_op   <= 6'd0;
      r_cnt  <= 2'd0;
      r_hold <= 8'h00;
    end else begin
      if (w_accept) begin
        ai    <= rd_data;
        bi    <= rr_data;
        r_op  <= 6'd1 << op_sel;
        r_cnt <= CNT_INIT;
      end else if ((r_state == S_EXEC) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (r_state == S_WB) begin
        r_hold <= mu_ro[15:8];
      end
    end
  end

  assign op_mul    = w_op_act & r_op[0];
  assign op_muls   = w_op_act & r_op[1];
  assign op_mulsu  = w_op_act & r_op[2];
  assign op_fmul   = w_op_act & r_op[3];
  assign op_fmuls  = w_op_act & r_op[4];
  assign op_fmulsu = w_op_act & r_op[5];

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer
module tb_mul_sequencer;

  // Instance 0: defaults. Instance 1: PAIR_WR=0. Instance 2: IREG=0, OREG=1, PAIR_WR=0.
  localparam int LAT = 1;

  logic        clock;
  logic        reset_n;
  logic        start [3];
  logic [2:0]  op_sel;
  logic [7:0]  rd_data;
  logic [7:0]  rr_data;
  logic        busy [3];
  logic [7:0]  ai [3];
  logic [7:0]  bi [3];
  logic [5:0]  ops [3];
  logic [17:0] mu [3];
  logic        wr_en [3];
  logic        wr_pair [3];
  logic [4:0]  wr_addr [3];
  logic [15:0] wr_data [3];
  logic        sreg_we [3];
  logic        sreg_c [3];
  logic        sreg_z [3];
  logic        done [3];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tbl [8];

  // Architectural result of an AVR multiply, from the opcode: {C, Z, product}.
  function automatic logic [17:0] ref_mul(input logic [2:0] code, input logic [7:0] a,
                                          input logic [7:0] b);
    int sa;
    int sb;
    int p;
    logic [15:0] raw;
    logic [15:0] res;
    sa  = (code == 3'd1 || code == 3'd2 || code == 3'd4 || code == 3'd5) ? int'($signed(a)) : int'(a);
    sb  = (code == 3'd1 || code == 3'd4) ? int'($signed(b)) : int'(b);
    p   = sa * sb;
    raw = p[15:0];
    res = (code >= 3'd3) ? {raw[14:0], 1'b0} : raw;
    return {raw[15], (res == 16'h0000), res};
  endfunction

  // Multiplier behaviour seen from its enables: no single enable means zero result and flags.
  function automatic logic [17:0] mu_model(input logic [5:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [2:0] code;
    code = 3'd0;
    if ($countones(op) != 1) return 18'd0;
    for (int i = 0; i < 6; i++) if (op[i]) code = 3'(i);
    return ref_mul(code, a, b);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mul_sequencer #(
      .IREG    ((gi == 2) ? 0 : 1),
      .OREG    ((gi == 2) ? 1 : 0),
      .PAIR_WR ((gi == 0) ? 1 : 0)
    ) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start[gi]),
      .op_sel    (op_sel),
      .rd_data   (rd_data),
      .rr_data   (rr_data),
      .busy      (busy[gi]),
      .ai        (ai[gi]),
      .bi        (bi[gi]),
      .op_mul    (ops[gi][0]),
      .op_muls   (ops[gi][1]),
      .op_mulsu  (ops[gi][2]),
      .op_fmul   (ops[gi][3]),
      .op_fmuls  (ops[gi][4]),
      .op_fmulsu (ops[gi][5]),
      .mu_ro     (mu[gi][15:0]),
      .mu_cf     (mu[gi][17]),
      .mu_zf     (mu[gi][16]),
      .wr_en     (wr_en[gi]),
      .wr_pair   (wr_pair[gi]),
      .wr_addr   (wr_addr[gi]),
      .wr_data   (wr_data[gi]),
      .sreg_we   (sreg_we[gi]),
      .sreg_c    (sreg_c[gi]),
      .sreg_z    (sreg_z[gi]),
      .done      (done[gi])
    );

    logic [21:0] r_q;
    logic [17:0] r_o;

    // Multiplier pipeline register: input side for IREG=1, output side for OREG=1.
    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
        r_o <= '0;
      end else begin
        r_q <= {ops[gi], ai[gi], bi[gi]};
        r_o <= mu_model(ops[gi], ai[gi], bi[gi]);
      end
    end

    if (gi < 2) begin : g_ireg
      assign mu[gi] = mu_model(r_q[21:16], r_q[15:8], r_q[7:0]);
    end else begin : g_oreg
      assign mu[gi] = r_o;
    end
  end

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] allout(input int i);
    return {14'd0, busy[i], ai[i], bi[i], ops[i], wr_en[i], wr_pair[i], wr_addr[i],
            wr_data[i], sreg_we[i], sreg_c[i], sreg_z[i], done[i]};
  endfunction

  // Issue one instruction at the current cycle (cycle 0) and check every cycle through
  // the first idle cycle after the final write; returns in that idle cycle.
  task automatic run_op(input int idx, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] res, input logic c,
                        input logic z);
    bit pair;
    bit ewb;
    bit ehi;
    int last;
    string p;
    pair = (idx == 0);
    last = pair ? 1 + LAT : 2 + LAT;
    op_sel     = op;
    rd_data    = a;
    rr_data    = b;
    start[idx] = 1'b1;
    tick();
    start[idx] = 1'b0;
    op_sel     = 3'($urandom_range(0, 7));
    rd_data    = 8'($urandom);
    rr_data    = 8'($urandom);
    for (int k = 1; k <= last + 1; k++) begin
      p   = $sformatf("i%0d op%0d c%0d", idx, op, k);
      ewb = (k == 1 + LAT);
      ehi = !pair && (k == 2 + LAT);
      chk({p, " busy"}, busy[idx], (k <= last));
      chk({p, " ops"}, ops[idx], (k <= 1 + LAT) ? (64'd1 << op) : 64'd0);
      chk({p, " wr_en"}, wr_en[idx], ewb || ehi);
      chk({p, " sreg_we"}, sreg_we[idx], ewb);
      chk({p, " done"}, done[idx], (ewb && pair) || ehi);
      if (k <= 1 + LAT) begin
        chk({p, " ai"}, ai[idx], a);
        chk({p, " bi"}, bi[idx], b);
      end
      if (ewb) begin
        chk({p, " wr_pair"}, wr_pair[idx], pair);
        chk({p, " wr_addr"}, wr_addr[idx], 5'd0);
        chk({p, " wr_data"}, wr_data[idx], pair ? res : {8'h00, res[7:0]});
        chk({p, " sreg_c"}, sreg_c[idx], c);
        chk({p, " sreg_z"}, sreg_z[idx], z);
      end
      if (ehi) begin
        chk({p, " wr_pair"}, wr_pair[idx], 1'b0);
        chk({p, " wr_addr"}, wr_addr[idx], 5'd1);
        chk({p, " wr_data"}, wr_data[idx], {8'h00, res[15:8]});
      end
      if (k <= last) tick();
    end
  endtask

  initial begin
    int nwr;
    logic [17:0] r;
    logic [2:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;
    int idx;

    tbl[0] = '{3'd0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0};
    tbl[1] = '{3'd1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 8'hFF, 8'h02, 16'hFFFE, 1'b1, 1'b0};
    tbl[3] = '{3'd3, 8'h80, 8'h80, 16'h8000, 1'b0, 1'b0};
    tbl[4] = '{3'd0, 8'h00, 8'h55, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{3'd0, 8'h12, 8'h34, 16'h03A8, 1'b0, 1'b0};
    tbl[6] = '{3'd4, 8'hC0, 8'h40, 16'hE000, 1'b1, 1'b0};
    tbl[7] = '{3'd5, 8'h40, 8'hFF, 16'h7F80, 1'b0, 1'b0};

    clock   = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    op_sel  = 3'd0;
    rd_data = 8'h00;
    rr_data = 8'h00;
    #2;
    for (int i = 0; i < 3; i++) chk($sformatf("i%0d reset outputs", i), allout(i), 64'd0);
    tick();
    reset_n = 1'b1;

    // Table vectors on every instance, back to back.
    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 8; v++)
        run_op(i, tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].res, tbl[v].c, tbl[v].z);

    // Start while busy must be ignored: exactly one write of the first product.
    op_sel = 3'd0; rd_data = 8'h03; rr_data = 8'h05; start[0] = 1'b1;
    tick();
    op_sel = 3'd0; rd_data = 8'h07; rr_data = 8'h07;
    tick();
    start[0] = 1'b0;
    chk("busy-start wr_data", wr_data[0], 16'h000F);
    nwr = 0;
    for (int k = 0; k < 4; k++) begin
      if (wr_en[0]) nwr++;
      tick();
    end
    chk("busy-start write count", nwr, 1);
    chk("busy-start idle after", busy[0], 1'b0);

    // Illegal opcodes are ignored in IDLE.
    for (int i = 0; i < 3; i++) begin
      op_sel = (i == 1) ? 3'd6 : 3'd7; start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      chk($sformatf("i%0d illegal busy", i), busy[i], 1'b0);
      chk($sformatf("i%0d illegal ops", i), ops[i], 6'd0);
      tick();
      chk($sformatf("i%0d illegal wr_en", i), wr_en[i], 1'b0);
    end

    // Reset in cycle 1 of a MUL: immediate zero outputs, no write, first start accepted.
    op_sel = 3'd0; rd_data = 8'hFF; rr_data = 8'hFF; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("abort busy before reset", busy[0], 1'b1);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("i%0d abort outputs", i), allout(i), 64'd0);
    tick();
    chk("abort wr_en in reset", wr_en[0], 1'b0);
    reset_n = 1'b1;
    tick();
    chk("abort no late write", wr_en[0], 1'b0);
    chk("abort idle", busy[0], 1'b0);
    run_op(0, 3'd0, 8'h12, 8'h34, 16'h03A8, 1'b0, 1'b0);

    // Random instructions against the architectural model, with idle gaps and stray illegal starts.
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 2);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        if ($urandom_range(0, 1) == 1) begin
          op_sel = 3'($urandom_range(6, 7));
          start[idx] = 1'b1;
        end
        tick();
        start[idx] = 1'b0;
        chk($sformatf("rand i%0d gap busy", idx), busy[idx], 1'b0);
      end
      rop = 3'($urandom_range(0, 5));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      r   = ref_mul(rop, ra, rb);
      run_op(idx, rop, ra, rb, r[15:0], r[17], r[16]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
